// File: rtl/square_table_dumper_if.sv
// Byte-stream channel from the square table dumper to its sink.
// The master drives data/valid, the slave answers with ready.
interface square_table_dumper_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/square_table_dumper.sv
// Fills a table with index^2 on a start pulse, then streams every entry
// out MSB byte first over a valid/ready channel.
module square_table_dumper #(
  parameter int VAL_W = 6,
  parameter int DEPTH = 64,
  parameter int BYTES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [VAL_W-1:0]         fill_idx,
  square_table_dumper_if.master    stream
);

  localparam int ENTRY_W = 8 * BYTES;
  localparam int BYTE_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [VAL_W-1:0]  LAST_IDX  = VAL_W'(DEPTH - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_t;

  state_t              state_reg;
  logic [VAL_W-1:0]    wr_idx_reg;
  logic [VAL_W-1:0]    rd_idx_reg;
  logic [BYTE_W-1:0]   byte_idx_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                out_valid_reg;

  logic [ENTRY_W-1:0]  table_mem [DEPTH];
  logic [ENTRY_W-1:0]  rd_word_reg;
  logic [ENTRY_W-1:0]  wr_word;
  logic [2*VAL_W-1:0]  square;
  logic [ADDR_W-1:0]   rd_addr_next;
  logic [7:0]          entry_bytes [BYTES];
  logic [BYTE_W-1:0]   byte_sel;
  logic                wr_en;
  logic                transfer;
  logic                byte_wrap;

  assign square    = {{VAL_W{1'b0}}, wr_idx_reg} * {{VAL_W{1'b0}}, wr_idx_reg};
  assign wr_word   = ENTRY_W'(square);
  assign wr_en     = (state_reg == FILL);
  assign transfer  = out_valid_reg & stream.out_ready;
  assign byte_wrap = (byte_idx_reg == LAST_BYTE);

  // The read address runs one step ahead so rd_word_reg always holds
  // table[rd_idx_reg]; it parks on entry 0 outside DRAIN.
  always_comb begin
    rd_addr_next = '0;
    if (state_reg == DRAIN) begin
      rd_addr_next = rd_idx_reg[ADDR_W-1:0];
      if (transfer && byte_wrap) begin
        rd_addr_next = rd_idx_reg[ADDR_W-1:0] + ADDR_W'(1);
      end
    end
  end

  // With a single entry, entry 0 is written on the same edge it must be
  // read, so that one case forwards the write data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_mem[wr_idx_reg[ADDR_W-1:0]] <= wr_word;
    end
    if ((DEPTH == 1) && wr_en) begin
      rd_word_reg <= wr_word;
    end else begin
      rd_word_reg <= table_mem[rd_addr_next];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      wr_idx_reg    <= '0;
      rd_idx_reg    <= '0;
      byte_idx_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg  <= FILL;
            busy_reg   <= 1'b1;
            wr_idx_reg <= '0;
          end
        end
        FILL: begin
          // Terminate on the compare so a full 2**VAL_W table never wraps.
          if (wr_idx_reg == LAST_IDX) begin
            state_reg     <= DRAIN;
            wr_idx_reg    <= '0;
            rd_idx_reg    <= '0;
            byte_idx_reg  <= '0;
            out_valid_reg <= 1'b1;
          end else begin
            wr_idx_reg <= wr_idx_reg + VAL_W'(1);
          end
        end
        DRAIN: begin
          if (transfer) begin
            if (byte_wrap) begin
              byte_idx_reg <= '0;
              if (rd_idx_reg == LAST_IDX) begin
                state_reg     <= DONE;
                busy_reg      <= 1'b0;
                out_valid_reg <= 1'b0;
                done_reg      <= 1'b1;
                rd_idx_reg    <= '0;
              end else begin
                rd_idx_reg <= rd_idx_reg + VAL_W'(1);
              end
            end else begin
              byte_idx_reg <= byte_idx_reg + BYTE_W'(1);
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_entry_bytes
      assign entry_bytes[gi] = rd_word_reg[8*gi +: 8];
    end
  endgenerate

  assign byte_sel         = LAST_BYTE - byte_idx_reg;
  assign stream.out_data  = out_valid_reg ? entry_bytes[byte_sel] : 8'h00;
  assign stream.out_valid = out_valid_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign fill_idx         = wr_idx_reg;

endmodule

// File: tb/tb_square_table_dumper.sv
// Directed bench for square_table_dumper: default build plus two
// parameter variants sharing one clock and reset.
module tb_square_table_dumper;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Default build: VAL_W=6, DEPTH=64, BYTES=2
  logic       start0 = 1'b0;
  logic       busy0, done0;
  logic [5:0] fill_idx0;
  square_table_dumper_if if0 ();
  square_table_dumper #(.VAL_W(6), .DEPTH(64), .BYTES(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0),
    .done(done0), .fill_idx(fill_idx0), .stream(if0.master)
  );

  // Small variant: VAL_W=4, DEPTH=10, BYTES=1
  logic       start1 = 1'b0;
  logic       busy1, done1;
  logic [3:0] fill_idx1;
  square_table_dumper_if if1 ();
  square_table_dumper #(.VAL_W(4), .DEPTH(10), .BYTES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1),
    .done(done1), .fill_idx(fill_idx1), .stream(if1.master)
  );

  // Full-depth variant: VAL_W=8, DEPTH=256, BYTES=3
  logic       start2 = 1'b0;
  logic       busy2, done2;
  logic [7:0] fill_idx2;
  square_table_dumper_if if2 ();
  square_table_dumper #(.VAL_W(8), .DEPTH(256), .BYTES(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2),
    .done(done2), .fill_idx(fill_idx2), .stream(if2.master)
  );

  function automatic logic [7:0] exp_byte0(input int n);
    int idx;
    int sq;
    idx = n / 2;
    sq  = idx * idx;
    return (n % 2 == 0) ? 8'(sq >> 8) : 8'(sq);
  endfunction

  // One run of the default build. rnd: random ready; stop_after: return
  // once that many transfers are committed; poke: stray starts in
  // FILL/DRAIN/DONE; chain: return on the done cycle.
  task automatic run0(input bit rnd, input int stop_after, input bit poke,
                      input bit chain, input string name);
    int fill_cnt = 0;
    int ndone = 0;
    int nbytes = 0;
    int cyc = 0;
    int post = 0;
    bit seen_done = 0;
    bit last_stall = 0;
    logic [7:0] last_data = 8'h00;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check({name, "_busy_rise"}, busy0, 1);
    while (busy0 && !if0.out_valid && cyc < 1000) begin
      check({name, "_fill_idx"}, fill_idx0, fill_cnt);
      start0 = poke && (fill_cnt == 10);
      fill_cnt++;
      cyc++;
      @(negedge clk);
    end
    start0 = 1'b0;
    check({name, "_fill_cycles"}, fill_cnt, 64);
    while (cyc < 5000) begin
      if (if0.out_valid) begin
        if (last_stall) check({name, "_stall_stable"}, if0.out_data, last_data);
      end else begin
        check({name, "_data_zero"}, if0.out_data, 0);
      end
      if (done0) begin
        ndone++;
        seen_done = 1;
        check({name, "_bytes_at_done"}, nbytes, 128);
        check({name, "_busy_at_done"}, busy0, 0);
        check({name, "_valid_at_done"}, if0.out_valid, 0);
        if (chain) break;
      end else if (seen_done) begin
        check({name, "_busy_post"}, busy0, 0);
      end
      start0 = poke && (nbytes == 50 || done0);
      if0.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (if0.out_valid && if0.out_ready) begin
        check({name, "_byte"}, if0.out_data, exp_byte0(nbytes));
        nbytes++;
      end
      last_stall = if0.out_valid && !if0.out_ready;
      last_data  = if0.out_data;
      if (stop_after != 0 && nbytes == stop_after) break;
      if (seen_done) post++;
      if (post > 4) break;
      cyc++;
      @(negedge clk);
    end
    start0 = 1'b0;
    check({name, "_in_budget"}, cyc < 5000, 1);
    if (stop_after == 0) begin
      check({name, "_done_pulses"}, ndone, 1);
      check({name, "_total_bytes"}, nbytes, 128);
    end
    $display("run %s: fill=%0d bytes=%0d done=%0d", name, fill_cnt, nbytes, ndone);
  endtask

  task automatic run1();
    logic [7:0] v1 [10] = '{8'h00, 8'h01, 8'h04, 8'h09, 8'h10,
                            8'h19, 8'h24, 8'h31, 8'h40, 8'h51};
    int fill_cnt = 0;
    int n = 0;
    int cyc = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (busy1 && !if1.out_valid && cyc < 200) begin
      fill_cnt++;
      cyc++;
      @(negedge clk);
    end
    check("v1_fill_cycles", fill_cnt, 10);
    while (!done1 && cyc < 400) begin
      if (if1.out_valid) begin
        if (n < 10) check("v1_byte", if1.out_data, v1[n]);
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    check("v1_done_seen", done1, 1);
    check("v1_total_bytes", n, 10);
    $display("run v1: fill=%0d bytes=%0d", fill_cnt, n);
  endtask

  task automatic run2();
    logic [7:0] got [768];
    int fill_cnt = 0;
    int n = 0;
    int cyc = 0;
    int err = 0;
    int last_fill = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (busy2 && !if2.out_valid && cyc < 1000) begin
      last_fill = int'(fill_idx2);
      fill_cnt++;
      cyc++;
      @(negedge clk);
    end
    check("v2_fill_cycles", fill_cnt, 256);
    check("v2_last_fill_idx", last_fill, 255);
    while (!done2 && cyc < 3000) begin
      if (if2.out_valid) begin
        if (n < 768) begin
          got[n] = if2.out_data;
          if (if2.out_data != 8'(((n / 3) * (n / 3)) >> (8 * (2 - n % 3)))) err++;
        end
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    check("v2_done_seen", done2, 1);
    check("v2_total_bytes", n, 768);
    check("v2_stream_errors", err, 0);
    check("v2_entry255", {got[765], got[766], got[767]}, 24'h00FE01);
    check("v2_entry16", {got[48], got[49], got[50]}, 24'h000100);
    $display("run v2: fill=%0d bytes=%0d", fill_cnt, n);
  endtask

  initial begin
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    if2.out_ready = 1'b1;
    #1 reset = 1'b1;
    #12;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_valid", if0.out_valid, 0);
    check("rst_data", if0.out_data, 0);
    check("rst_fill_idx", fill_idx0, 0);
    @(negedge clk);
    reset = 1'b0;

    run0(1'b0, 0, 1'b0, 1'b0, "basic");
    run0(1'b1, 0, 1'b0, 1'b0, "backpressure");

    run0(1'b0, 40, 1'b0, 1'b0, "pre_reset");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_valid", if0.out_valid, 0);
    check("midrst_data", if0.out_data, 0);
    check("midrst_fill_idx", fill_idx0, 0);
    @(negedge clk);
    reset = 1'b0;
    run0(1'b0, 0, 1'b0, 1'b0, "after_reset");

    run0(1'b0, 0, 1'b1, 1'b0, "stray_start");
    run0(1'b0, 0, 1'b0, 1'b1, "chain_a");
    run0(1'b1, 0, 1'b0, 1'b0, "chain_b");

    run1();
    run2();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/square_table_dumper.md
Name: square_table_dumper

Overview:
Synthesizable successor to the square-table capture flow. On a start pulse it sweeps an index 0..DEPTH-1, computes index squared, and stores each result zero-extended into an internal table of BYTES-byte entries. It then streams the table out as a big-endian byte stream over a valid/ready interface, feeding a host-side binary writer or a UART/FIFO. Value width, table depth and bytes per entry are parameters.

Parameters:
VAL_W, 6, index width in bits; squares are 2*VAL_W bits wide.
DEPTH, 64, number of table entries; 1 <= DEPTH <= 2**VAL_W.
BYTES, 2, bytes per stored entry; 8*BYTES >= 2*VAL_W is a legal-parameter requirement.

Ports:
clk  in  1  clock, all state on the rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to run fill then drain; sampled only in IDLE.
busy  out  1  high in FILL and DRAIN.
done  out  1  one-cycle pulse after the last byte is accepted.
fill_idx  out  VAL_W  index currently being written; holds 0 outside FILL.
out_data  out  8  current output byte.
out_valid  out  1  out_data is valid (DRAIN only).
out_ready  in  1  sink accepts out_data when high together with out_valid.

Behaviour:
- Reset asserted, at any time and in any state: state=IDLE, busy=0, done=0, fill_idx=0, out_valid=0, out_data=0, all internal pointers cleared. Table contents are not reset and are don't-care until refilled. The first edge after reset deasserts sees IDLE.
- States are IDLE, FILL, DRAIN and DONE.
- IDLE: if start=1 on an edge, go to FILL with wr_idx=0. Otherwise stay. start is ignored in every other state, with no queuing.
- FILL: one entry per cycle. On each edge, table[wr_idx] gets the zero-extended value wr_idx*wr_idx, truncated to 8*BYTES bits, which is a no-op when the legality rule holds.
  - wr_idx increments each edge. After the edge that writes index DEPTH-1, go to DRAIN with rd_idx=0 and byte_idx=0.
  - FILL lasts exactly DEPTH cycles.
  - fill_idx mirrors wr_idx.
- DRAIN: out_valid=1 in every DRAIN cycle. out_data is byte (BYTES-1-byte_idx) of table[rd_idx], i.e. MSB byte first.
  - A transfer is out_valid & out_ready on an edge.
  - On a transfer, byte_idx increments. When byte_idx wraps from BYTES-1 to 0, rd_idx increments.
  - Without a transfer, out_data and the pointers hold stable, with no bubble and no drop.
  - The transfer of the last byte (rd_idx=DEPTH-1, byte_idx=BYTES-1) moves to DONE.
  - Total transfers are DEPTH*BYTES.
- DONE: done=1, busy=0, out_valid=0 for exactly one cycle, then IDLE. A start arriving in DONE is ignored.
- Timing from start sampled at edge E0:
  - busy rises after E0.
  - The first out_valid appears after edge E0+DEPTH.
  - With out_ready tied high, done is high in the cycle after edge E0+DEPTH+DEPTH*BYTES.
- out_data is 0 whenever out_valid=0.
- Arithmetic: the product is unsigned, full 2*VAL_W bits, with no saturation. The index counter must not overflow into the wrong entry when DEPTH=2**VAL_W; terminate on the index compare, not on the counter wrap.
- Back-to-back runs: a new start is accepted in the first IDLE cycle after DONE. The table is fully rewritten with identical content.

Test Plan:
- Defaults, out_ready=1, one start pulse:
  - busy high for 64 FILL cycles, then 128 valid bytes.
  - Byte sequence is 00 00, 00 01, 00 04, 00 09, ..., 0F 81 (63²=3969).
  - done pulses once, the cycle after byte 128; busy is low from then on.
- Backpressure: defaults with out_ready driven by a pseudo-random pattern (≈50% duty):
  - Stream is identical to the first scenario.
  - out_data is stable across every valid & !ready cycle.
  - Exactly 128 transfers.
- Reset mid-run: assert reset asynchronously, off a clock edge, after 40 bytes have been accepted.
  - All outputs go to 0 immediately; state returns to IDLE.
  - A new start replays the full 128-byte sequence from 00 00.
- start during FILL, DRAIN and DONE:
  - No effect: the stream count stays 128, with a single done.
  - start pulsed the cycle after done begins a second identical run.
- Parameter variant VAL_W=8, DEPTH=256, BYTES=3:
  - 768 bytes; entry 255 = 00 FE 01, entry 16 = 00 01 00.
  - The index compare terminates correctly at the full 2**VAL_W depth.
- Parameter variant VAL_W=4, DEPTH=10, BYTES=1:
  - 10 bytes: 00 01 04 09 10 19 24 31 40 51.
  - FILL lasts 10 cycles.
